jump_ras_ctrl: RTL and testbench

Registered jump/jump-register control unit with a parametrised return-address stack (RAS). It decodes J, JAL, JR and JALR from decode-stage fields and produces the PC-select code and resolved jump target one cycle later. It pushes return addresses on JAL/JALR and pops them on JR $ra, then flags a hit or miss by comparing the popped prediction with the actual register value. It sits between the decode/register-file stage and the PC control; its target output is always driven and is never tri-stated.

---
 rtl/jump_ras_ctrl.sv | 153 +++++++++++++++
 tb/tb_jump_ras_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jump_ras_ctrl.sv
// Registered J/JAL/JR/JALR decode with a circular return-address stack.
// Outputs reflect the instruction presented in the previous un-stalled cycle.
module jump_ras_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter logic [2:0]  PCOP_JR  = 3'b100,
    parameter logic [2:0]  PCOP_J   = 3'b011,
    parameter logic [2:0]  PCOP_SEQ = 3'b000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [5:0]               opcode,
    input  logic [3:0]               alu_op,
    input  logic [5:0]               func,
    input  logic [4:0]               rs_addr,
    input  logic [WIDTH-1:0]         read_data1,
    input  logic [WIDTH-1:0]         pc_plus4,
    input  logic [25:0]              jindex,
    output logic [2:0]               pc_op,
    output logic [WIDTH-1:0]         jump_target,
    output logic                     target_valid,
    output logic [WIDTH-1:0]         ras_pred,
    output logic                     ras_hit,
    output logic                     ras_miss,
    output logic [$clog2(DEPTH):0]   ras_count,
    output logic                     ras_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [AW-1:0]    tp_q, tp_n, waddr;
    logic [CW-1:0]    cnt_n;
    logic             we;
    logic             is_jr, is_jalr, is_j, is_jal;
    logic             do_push, do_pop;
    logic             hit_n, miss_n, ovf_n;
    logic [2:0]       pc_op_n;
    logic [WIDTH-1:0] target_n, pred_n;
    logic             tv_n;

    always_comb begin
        is_jr   = valid_in && (alu_op == 4'b0010) && (func == 6'b001000);
        is_jalr = valid_in && (alu_op == 4'b0010) && (func == 6'b001001);
        is_j    = valid_in && (opcode == 6'b000010);
        is_jal  = valid_in && (opcode == 6'b000011);
        do_push = is_jal || is_jalr;
        do_pop  = (is_jr || is_jalr) && (rs_addr == 5'd31);
    end

    always_comb begin
        pc_op_n  = PCOP_SEQ;
        target_n = '0;
        tv_n     = 1'b0;
        if (is_jr || is_jalr) begin
            pc_op_n  = PCOP_JR;
            target_n = read_data1;
            tv_n     = 1'b1;
        end else if (is_j || is_jal) begin
            pc_op_n  = PCOP_J;
            target_n = {pc_plus4[WIDTH-1:28], jindex, 2'b00};
            tv_n     = 1'b1;
        end
    end

    // JALR $ra on a non-empty stack overwrites the popped slot in place,
    // so the pop and push cancel out in tp/cnt.
    always_comb begin
        tp_n   = tp_q;
        cnt_n  = ras_count;
        we     = 1'b0;
        waddr  = tp_q + AW'(1);
        hit_n  = 1'b0;
        miss_n = 1'b0;
        ovf_n  = ras_overflow;
        if (do_pop) begin
            if (ras_count == '0) begin
                miss_n = 1'b1;
            end else begin
                if (stack[tp_q] == read_data1) hit_n = 1'b1;
                else                           miss_n = 1'b1;
                if (!do_push) begin
                    tp_n  = tp_q - AW'(1);
                    cnt_n = ras_count - CW'(1);
                end
            end
        end
        if (do_push) begin
            we = 1'b1;
            if (do_pop && ras_count != '0) begin
                waddr = tp_q;
            end else begin
                waddr = tp_q + AW'(1);
                tp_n  = tp_q + AW'(1);
                if (ras_count == CW'(DEPTH)) ovf_n = 1'b1;
                else                         cnt_n = ras_count + CW'(1);
            end
        end
        if (cnt_n == '0)                 pred_n = '0;
        else if (we && (waddr == tp_n))  pred_n = pc_plus4;
        else                             pred_n = stack[tp_n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else if (!flush && !stall && we) begin
            stack[waddr] <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q         <= '0;
            ras_count    <= '0;
            ras_overflow <= 1'b0;
            pc_op        <= '0;
            jump_target  <= '0;
            target_valid <= 1'b0;
            ras_pred     <= '0;
            ras_hit      <= 1'b0;
            ras_miss     <= 1'b0;
        end else if (flush) begin
            tp_q         <= '0;
            ras_count    <= '0;
            ras_overflow <= 1'b0;
            pc_op        <= '0;
            jump_target  <= '0;
            target_valid <= 1'b0;
            ras_pred     <= '0;
            ras_hit      <= 1'b0;
            ras_miss     <= 1'b0;
        end else if (stall) begin
            ras_hit      <= 1'b0;
            ras_miss     <= 1'b0;
        end else begin
            tp_q         <= tp_n;
            ras_count    <= cnt_n;
            ras_overflow <= ovf_n;
            pc_op        <= pc_op_n;
            jump_target  <= target_n;
            target_valid <= tv_n;
            ras_pred     <= pred_n;
            ras_hit      <= hit_n;
            ras_miss     <= miss_n;
        end
    end

endmodule

// File: tb/tb_jump_ras_ctrl.sv
// Directed-vector bench for jump_ras_ctrl with hand-computed expectations.
module tb_jump_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, stall, flush;
    logic [5:0]  opcode, func;
    logic [3:0]  alu_op;
    logic [4:0]  rs_addr;
    logic [31:0] read_data1, pc_plus4;
    logic [25:0] jindex;
    logic [2:0]  pc_op;
    logic [31:0] jump_target, ras_pred;
    logic        target_valid, ras_hit, ras_miss, ras_overflow;
    logic [3:0]  ras_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jump_ras_ctrl #(.WIDTH(32), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .opcode(opcode), .alu_op(alu_op), .func(func), .rs_addr(rs_addr),
        .read_data1(read_data1), .pc_plus4(pc_plus4), .jindex(jindex),
        .pc_op(pc_op), .jump_target(jump_target), .target_valid(target_valid),
        .ras_pred(ras_pred), .ras_hit(ras_hit), .ras_miss(ras_miss),
        .ras_count(ras_count), .ras_overflow(ras_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [5:0] opc, input logic [3:0] aop,
                         input logic [5:0] fn, input logic [4:0] rs,
                         input logic [31:0] rd1, input logic [31:0] pc4,
                         input logic [25:0] ji);
        valid_in = v; opcode = opc; alu_op = aop; func = fn; rs_addr = rs;
        read_data1 = rd1; pc_plus4 = pc4; jindex = ji;
        @(posedge clk);
        #1;
    endtask

    task automatic jal(input logic [31:0] pc4, input logic [25:0] ji);
        issue(1'b1, 6'b000011, 4'b0000, 6'h00, 5'd0, 32'h0, pc4, ji);
    endtask

    task automatic jr(input logic [4:0] rs, input logic [31:0] rd1);
        issue(1'b1, 6'b000000, 4'b0010, 6'b001000, rs, rd1, 32'h0, 26'h0);
    endtask

    task automatic jalr(input logic [4:0] rs, input logic [31:0] rd1, input logic [31:0] pc4);
        issue(1'b1, 6'b000000, 4'b0010, 6'b001001, rs, rd1, pc4, 26'h0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        opcode = '0; alu_op = '0; func = '0; rs_addr = '0;
        read_data1 = '0; pc_plus4 = '0; jindex = '0;
        #1;
        check("rst_pc_op", {29'h0, pc_op}, 32'h0);
        check("rst_count", {28'h0, ras_count}, 32'h0);
        check("rst_pred", ras_pred, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // valid_in low masks a J opcode
        issue(1'b0, 6'b000010, 4'b0000, 6'h00, 5'd0, 32'h0, 32'h0040_0010, 26'h0100040);
        check("novalid_pc_op", {29'h0, pc_op}, 32'h0);
        check("novalid_tv", {31'h0, target_valid}, 32'h0);
        // plain J: target computed, no push
        issue(1'b1, 6'b000010, 4'b0000, 6'h00, 5'd0, 32'h0, 32'hA000_0000, 26'h0000001);
        check("j_target", jump_target, 32'hA000_0004);
        check("j_count", {28'h0, ras_count}, 32'h0);

        // JAL then JR $ra
        jal(32'h0040_0010, 26'h0100040);
        check("jal_pc_op", {29'h0, pc_op}, 32'h3);
        check("jal_target", jump_target, 32'h0040_0100);
        check("jal_tv", {31'h0, target_valid}, 32'h1);
        check("jal_pred", ras_pred, 32'h0040_0010);
        check("jal_count", {28'h0, ras_count}, 32'h1);
        jr(5'd31, 32'h0040_0010);
        check("jr_pc_op", {29'h0, pc_op}, 32'h4);
        check("jr_target", jump_target, 32'h0040_0010);
        check("jr_hit", {31'h0, ras_hit}, 32'h1);
        check("jr_miss", {31'h0, ras_miss}, 32'h0);
        check("jr_count", {28'h0, ras_count}, 32'h0);
        check("jr_pred", ras_pred, 32'h0);
        issue(1'b1, 6'h23, 4'b0000, 6'h00, 5'd0, 32'h0, 32'h0, 26'h0);
        check("hit_pulse_drop", {31'h0, ras_hit}, 32'h0);
        check("seq_target", jump_target, 32'h0);

        // JR via non-$ra leaves the stack, then mispredict
        jal(32'h0000_1000, 26'h0);
        jr(5'd5, 32'h0000_1234);
        check("jr5_target", jump_target, 32'h0000_1234);
        check("jr5_hitmiss", {30'h0, ras_hit, ras_miss}, 32'h0);
        check("jr5_count", {28'h0, ras_count}, 32'h1);
        jr(5'd31, 32'h0000_2000);
        check("mis_miss", {31'h0, ras_miss}, 32'h1);
        check("mis_hit", {31'h0, ras_hit}, 32'h0);
        check("mis_count", {28'h0, ras_count}, 32'h0);

        // overflow and wrap
        do_reset();
        for (int k = 1; k <= 9; k++) jal(32'(4 * k), 26'h0);
        check("ovf_count", {28'h0, ras_count}, 32'h8);
        check("ovf_flag", {31'h0, ras_overflow}, 32'h1);
        check("ovf_pred", ras_pred, 32'd36);
        for (int k = 9; k >= 2; k--) begin
            jr(5'd31, 32'(4 * k));
            check("wrap_hit", {31'h0, ras_hit}, 32'h1);
            check("wrap_count", {28'h0, ras_count}, 32'(k - 2));
        end
        jr(5'd31, 32'd4);
        check("empty_miss", {31'h0, ras_miss}, 32'h1);
        check("empty_count", {28'h0, ras_count}, 32'h0);
        check("ovf_sticky", {31'h0, ras_overflow}, 32'h1);

        // stall holds, then flush beats stall
        jal(32'h0000_0040, 26'h0000010);
        stall = 1'b1;
        jr(5'd31, 32'h0000_0040);
        check("stall_pc_op", {29'h0, pc_op}, 32'h3);
        check("stall_target", jump_target, 32'h0000_0040);
        check("stall_count", {28'h0, ras_count}, 32'h1);
        check("stall_hit", {31'h0, ras_hit}, 32'h0);
        flush = 1'b1;
        jr(5'd31, 32'h0000_0040);
        flush = 1'b0; stall = 1'b0;
        check("flush_pc_op", {29'h0, pc_op}, 32'h0);
        check("flush_tv", {31'h0, target_valid}, 32'h0);
        check("flush_count", {28'h0, ras_count}, 32'h0);
        check("flush_ovf", {31'h0, ras_overflow}, 32'h0);
        check("flush_pred", ras_pred, 32'h0);

        // JALR $ra on non-empty and empty stacks
        jal(32'h0000_0100, 26'h0);
        jalr(5'd31, 32'h0000_0100, 32'h0000_0200);
        check("jalr_hit", {31'h0, ras_hit}, 32'h1);
        check("jalr_count", {28'h0, ras_count}, 32'h1);
        check("jalr_pred", ras_pred, 32'h0000_0200);
        check("jalr_pc_op", {29'h0, pc_op}, 32'h4);
        jr(5'd31, 32'h0000_0200);
        jalr(5'd31, 32'h0000_0300, 32'h0000_0400);
        check("jalr_empty_miss", {31'h0, ras_miss}, 32'h1);
        check("jalr_empty_count", {28'h0, ras_count}, 32'h1);
        check("jalr_empty_pred", ras_pred, 32'h0000_0400);

        // asynchronous reset mid-operation
        jal(32'h10, 26'h1); jal(32'h20, 26'h2); jal(32'h30, 26'h3);
        check("pre_rst_count", {28'h0, ras_count}, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", {28'h0, ras_count}, 32'h0);
        check("async_pc_op", {29'h0, pc_op}, 32'h0);
        check("async_tv", {31'h0, target_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
